// File: rtl/qarma_tweak_pkg.sv
// Shared constants and types for the QARMA tweak schedule: cell shuffle
// permutations, the omega-LFSR cell mask and the schedule state encoding.
package qarma_tweak_pkg;

    // Cell shuffle h, 4 bits per entry, entry 0 in the most significant nibble.
    localparam logic [63:0] H_PERM = {4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
                                      4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};

    localparam logic [63:0] H_INV_PERM = {4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd1, 4'd0, 4'd8,
                                          4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd2, 4'd3};

    // Bit 15 is cell 0.
    localparam logic [15:0] LFSR_MASK = 16'b1101_1000_1001_0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS_A = 2'd1,
        PASS_B = 2'd2
    } state_e;

    function automatic int perm_src(input logic [63:0] perm, input int idx);
        return int'(perm[63 - 4*idx -: 4]);
    endfunction

endpackage

// File: rtl/qarma_tweak_schedule_step.sv
// One combinational QARMA tweak update: forward (shuffle h, then omega-LFSR)
// or inverse (inverse LFSR, then inverse shuffle), selected by inv_i.
module qarma_tweak_step
    import qarma_tweak_pkg::*;
#(
    parameter int CELL_W = 8
) (
    input  logic [16*CELL_W-1:0] tk_i,
    input  logic                 inv_i,
    output logic [16*CELL_W-1:0] tk_o
);

    localparam int W   = 16 * CELL_W;
    localparam int TAP = (CELL_W == 4) ? 1 : 2;

    function automatic logic [CELL_W-1:0] lfsr_fwd(input logic [CELL_W-1:0] c);
        return {c[0] ^ c[TAP], c[CELL_W-1:1]};
    endfunction

    // Undo lfsr_fwd: the old low bit is recovered from the feedback bit.
    function automatic logic [CELL_W-1:0] lfsr_inv(input logic [CELL_W-1:0] c);
        return {c[CELL_W-2:0], c[CELL_W-1] ^ c[TAP-1]};
    endfunction

    logic [W-1:0] shf_s;
    logic [W-1:0] fwd_s;
    logic [W-1:0] unl_s;
    logic [W-1:0] bwd_s;

    for (genvar i = 0; i < 16; i++) begin : g_cell
        localparam int SRC_F = perm_src(H_PERM, i);
        localparam int SRC_I = perm_src(H_INV_PERM, i);

        assign shf_s[W-1-i*CELL_W -: CELL_W] = tk_i[W-1-SRC_F*CELL_W -: CELL_W];
        assign bwd_s[W-1-i*CELL_W -: CELL_W] = unl_s[W-1-SRC_I*CELL_W -: CELL_W];

        if (LFSR_MASK[15-i]) begin : g_lfsr
            assign fwd_s[W-1-i*CELL_W -: CELL_W] = lfsr_fwd(shf_s[W-1-i*CELL_W -: CELL_W]);
            assign unl_s[W-1-i*CELL_W -: CELL_W] = lfsr_inv(tk_i[W-1-i*CELL_W -: CELL_W]);
        end else begin : g_pass
            assign fwd_s[W-1-i*CELL_W -: CELL_W] = shf_s[W-1-i*CELL_W -: CELL_W];
            assign unl_s[W-1-i*CELL_W -: CELL_W] = tk_i[W-1-i*CELL_W -: CELL_W];
        end
    end

    assign tk_o = inv_i ? bwd_s : fwd_s;

endmodule

// File: rtl/qarma_tweak_schedule.sv
// Iterative QARMA tweak-schedule generator streaming one round tweak per handshake.
// Define QARMA_TWEAK_MIRROR_EN to append the reflected schedule (PASS_B).
module qarma_tweak_schedule
    import qarma_tweak_pkg::*;
#(
    parameter int CELL_W = 8,
    parameter int ROUNDS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 dir_i,
    input  logic [16*CELL_W-1:0] tweak_i,
    output logic [16*CELL_W-1:0] rtk_o,
    output logic                 rtk_valid_o,
    input  logic                 rtk_ready_i,
    output logic [7:0]           round_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int W = 16 * CELL_W;
    localparam logic [7:0] LAST_A = 8'(ROUNDS - 1);
`ifdef QARMA_TWEAK_MIRROR_EN
    localparam logic [7:0] LAST_B = 8'(2 * ROUNDS - 1);
`endif

    state_e       state_q, state_d;
    logic [W-1:0] tk_q, tk_d;
    logic [7:0]   round_q, round_d;
    logic         dir_q, dir_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         hs_s;
    logic         step_inv_s;
    logic [W-1:0] step_tk_s;

    assign hs_s = valid_q & rtk_ready_i;

    // The reflected pass walks the schedule back in the opposite direction.
`ifdef QARMA_TWEAK_MIRROR_EN
    assign step_inv_s = (state_q == PASS_B) ? ~dir_q : dir_q;
`else
    assign step_inv_s = dir_q;
`endif

    qarma_tweak_step #(.CELL_W(CELL_W)) u_step (
        .tk_i  (tk_q),
        .inv_i (step_inv_s),
        .tk_o  (step_tk_s)
    );

    // Next-state logic: load on start, advance on each handshake, finish after the last one.
    always_comb begin
        state_d = state_q;
        tk_d    = tk_q;
        round_d = round_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    tk_d    = tweak_i;
                    dir_d   = dir_i;
                    round_d = 8'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = PASS_A;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            PASS_A: begin
                if (hs_s) begin
                    if (round_q < LAST_A) begin
                        tk_d    = step_tk_s;
                        round_d = round_q + 8'd1;
                    end else begin
`ifdef QARMA_TWEAK_MIRROR_EN
                        // First reflected tweak repeats the last forward one.
                        round_d = round_q + 8'd1;
                        state_d = PASS_B;
`else
                        round_d = 8'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end else begin
                    state_d = PASS_A;
                end
            end
`ifdef QARMA_TWEAK_MIRROR_EN
            PASS_B: begin
                if (hs_s) begin
                    if (round_q < LAST_B) begin
                        tk_d    = step_tk_s;
                        round_d = round_q + 8'd1;
                    end else begin
                        round_d = 8'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = PASS_B;
                end
            end
`endif
            default: begin
                round_d = 8'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tk_q    <= '0;
            round_q <= 8'd0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tk_q    <= tk_d;
            round_q <= round_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rtk_o       = tk_q;
    assign rtk_valid_o = valid_q;
    assign round_o     = round_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_qarma_tweak_schedule.sv
// Self-checking bench for qarma_tweak_schedule: three instances (QARMA-128 with 8
// rounds, QARMA-64 with 5 rounds, QARMA-128 with 1 round) against a cell-level model.
module tb_qarma_tweak_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start_s, dir_s, rdy_s;
    logic [127:0] tw_s;
    int           sel;

    logic [127:0] rtk8, rtk1;
    logic [63:0]  rtk4;
    logic         v8, v4, v1, b8, b4, b1, d8, d4, d1;
    logic [7:0]   r8, r4, r1;

    logic [127:0] o_rtk;
    logic         o_v, o_busy, o_done;
    logic [7:0]   o_rnd;

    int checks   = 0;
    int failures = 0;
    logic [127:0] obs_log[$];

`ifdef QARMA_TWEAK_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    localparam int H_T[16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
    localparam int LPOS[7] = '{0, 1, 3, 4, 8, 11, 13};

    qarma_tweak_schedule #(.CELL_W(8), .ROUNDS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s && sel == 0), .dir_i(dir_s),
        .tweak_i(tw_s), .rtk_o(rtk8), .rtk_valid_o(v8), .rtk_ready_i(rdy_s),
        .round_o(r8), .busy_o(b8), .done_o(d8));

    qarma_tweak_schedule #(.CELL_W(4), .ROUNDS(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s && sel == 1), .dir_i(dir_s),
        .tweak_i(tw_s[63:0]), .rtk_o(rtk4), .rtk_valid_o(v4), .rtk_ready_i(rdy_s),
        .round_o(r4), .busy_o(b4), .done_o(d4));

    qarma_tweak_schedule #(.CELL_W(8), .ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s && sel == 2), .dir_i(dir_s),
        .tweak_i(tw_s), .rtk_o(rtk1), .rtk_valid_o(v1), .rtk_ready_i(rdy_s),
        .round_o(r1), .busy_o(b1), .done_o(d1));

    always_comb begin
        o_rtk = rtk8; o_v = v8; o_busy = b8; o_done = d8; o_rnd = r8;
        if (sel == 1) begin
            o_rtk = {64'd0, rtk4}; o_v = v4; o_busy = b4; o_done = d4; o_rnd = r4;
        end else if (sel == 2) begin
            o_rtk = rtk1; o_v = v1; o_busy = b1; o_done = d1; o_rnd = r1;
        end
    end

    function automatic int cw_of(input int s);
        return (s == 1) ? 4 : 8;
    endfunction

    function automatic int rounds_of(input int s);
        return (s == 0) ? 8 : ((s == 1) ? 5 : 1);
    endfunction

    function automatic int lfsr_fwd(input int b, input int cw);
        if (cw == 4) return (((b ^ (b >> 1)) & 1) << 3) | (b >> 1);
        return (((b ^ (b >> 2)) & 1) << 7) | (b >> 1);
    endfunction

    // Inverse LFSR found by searching for the preimage under the forward map.
    function automatic int lfsr_pre(input int y, input int cw);
        for (int v = 0; v < (1 << cw); v++)
            if (lfsr_fwd(v, cw) == y) return v;
        return -1;
    endfunction

    function automatic logic [127:0] model_step(input logic [127:0] t, input int cw, input bit inv);
        int c[16];
        int n[16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++)
            c[i] = int'((t >> ((15 - i) * cw)) & 128'((1 << cw) - 1));
        if (!inv) begin
            for (int i = 0; i < 16; i++) n[i] = c[H_T[i]];
            for (int p = 0; p < 7; p++) n[LPOS[p]] = lfsr_fwd(n[LPOS[p]], cw);
        end else begin
            for (int p = 0; p < 7; p++) c[LPOS[p]] = lfsr_pre(c[LPOS[p]], cw);
            for (int i = 0; i < 16; i++) n[H_T[i]] = c[i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res = res | (128'(n[i]) << ((15 - i) * cw));
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called just after a negedge; returns just after the negedge showing done_o.
    task automatic run(input int s, input logic [127:0] tw_in, input bit dir, input int pct, input bit noise);
        logic [127:0] exp_q[$];
        logic [127:0] t, tw;
        int r, n, k, cyc;
        r  = rounds_of(s);
        tw = (cw_of(s) == 4) ? (tw_in & 128'hFFFF_FFFF_FFFF_FFFF) : tw_in;
        t  = tw;
        for (int i = 0; i < r; i++) begin
            exp_q.push_back(t);
            t = model_step(t, cw_of(s), dir);
        end
        if (MIRROR)
            for (int i = r - 1; i >= 0; i--) exp_q.push_back(exp_q[i]);
        n = exp_q.size();
        obs_log.delete();
        sel = s; tw_s = tw; dir_s = dir; start_s = 1'b1;
        rdy_s = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
        @(negedge clk);
        start_s = 1'b0;
        k = 0; cyc = 0;
        while (k < n && cyc < 1000) begin
            check("valid", 128'(o_v), 128'd1);
            check("busy", 128'(o_busy), 128'd1);
            check("done_low", 128'(o_done), 128'd0);
            check("rtk", o_rtk, exp_q[k]);
            check("round", 128'(o_rnd), 128'(k));
            rdy_s   = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            start_s = noise && ($urandom_range(0, 3) == 0);
            tw_s    = rand128();
            dir_s   = $urandom_range(0, 1);
            if (o_v && rdy_s) begin
                obs_log.push_back(o_rtk);
                k++;
                if (k == n && noise) start_s = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        check("count", 128'(k), 128'(n));
        start_s = 1'b0;
        check("end_done", 128'(o_done), 128'd1);
        check("end_valid", 128'(o_v), 128'd0);
        check("end_busy", 128'(o_busy), 128'd0);
        check("end_round", 128'(o_rnd), 128'd0);
        check("end_rtk", o_rtk, exp_q[n-1]);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 128'(o_done), 128'd0);
        check({tag, "_busy"}, 128'(o_busy), 128'd0);
    endtask

    initial begin
        logic [127:0] t1, rtw;
        rst_n = 1'b0; start_s = 1'b0; dir_s = 1'b0; rdy_s = 1'b0; tw_s = '0; sel = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_rtk", o_rtk, 128'd0);
            check("rst_valid", 128'(o_v), 128'd0);
            check("rst_round", 128'(o_rnd), 128'd0);
            check("rst_busy", 128'(o_busy), 128'd0);
            check("rst_done", 128'(o_done), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 128'h01 << 120, 1'b0, 100, 1'b0);
        check("t1_cw8", obs_log[1], 128'h00000000_80000000_00000000_00000000);
        idle_check("pulse8");

        run(1, 128'h1000_0000_0000_0000, 1'b0, 100, 1'b0);
        t1 = obs_log[1];
        check("t1_cw4", t1, 128'h0000_8000_0000_0000);
        idle_check("pulse4");
        run(1, t1, 1'b1, 100, 1'b0);
        check("inv_back_cw4", obs_log[1], 128'h1000_0000_0000_0000);
        idle_check("pulse4b");

`ifdef QARMA_TWEAK_MIRROR_EN
        rtw = rand128();
        run(0, rtw, 1'b0, 100, 1'b0);
        check("mirror_repeat", obs_log[8], obs_log[7]);
        check("mirror_final", obs_log[15], rtw);
        idle_check("pulse_mirror");
`endif

        // Back-to-back randomized passes with stalls and stray start requests.
        for (int i = 0; i < 3; i++)
            run(0, rand128(), 1'($urandom_range(0, 1)), 30 + 20 * i, 1'b1);
        idle_check("chain8");
        for (int i = 0; i < 3; i++)
            run(1, rand128(), 1'($urandom_range(0, 1)), 40, 1'b1);
        idle_check("chain4");
        for (int i = 0; i < 2; i++)
            run(2, rand128(), 1'($urandom_range(0, 1)), 50, 1'b1);
        idle_check("chain1");

        // Asynchronous reset in the middle of a pass.
        sel = 0; tw_s = rand128(); dir_s = 1'b0; start_s = 1'b1; rdy_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 128'(o_busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rtk", o_rtk, 128'd0);
        check("arst_valid", 128'(o_v), 128'd0);
        check("arst_round", 128'(o_rnd), 128'd0);
        check("arst_busy", 128'(o_busy), 128'd0);
        check("arst_done", 128'(o_done), 128'd0);
        @(posedge clk);
        #1;
        check("arst_no_done", 128'(o_done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 128'(o_done), 128'd0);
        run(0, rand128(), 1'b1, 60, 1'b0);
        idle_check("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
